bsg_mem_1rw_sync_mask_write_bit_arb: RTL and testbench
======================================================

Name: bsg_mem_1rw_sync_mask_write_bit_arb

Overview:
- Two-requester controller in front of one bsg_mem_1rw_sync_mask_write_bit instance. The memory is configured with latch_last_read_p=1 and is instantiated by the parent.
- After reset, sequences a full clear of the array to zero.
- Afterwards, round-robin shares the single port between requesters 0 and 1 with valid/ready requests and valid/yumi read responses.
- Used wherever two agents (e.g. core and DMA) share one hardened tag/data SRAM.

Parameters:
width_p, -1 (required), data and mask width
els_p, -1 (required), number of memory entries
addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived, not overridden)
clear_on_reset_p, 1, 1 = zero all entries after reset; 0 = enter RUN immediately

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
v_i  in  2  request valid, per requester
w_i  in  2  1 = write, 0 = read
addr_i  in  2*addr_width_lp  request address; requester r uses slice r
data_i  in  2*width_p  write data
w_mask_i  in  2*width_p  write bit mask (1 = write the bit)
ready_o  out  2  request accepted this cycle when v_i&ready_o
v_o  out  2  read data valid for requester r
data_o  out  width_p  read data, shared by both requesters; qualified by v_o
yumi_i  in  2  response consumed; legal only when v_o[r]
clear_done_o  out  1  high once the clear sweep is finished
mem_v_o  out  1  memory port v_i
mem_w_o  out  1  memory port w_i
mem_addr_o  out  addr_width_lp  memory port addr_i
mem_data_o  out  width_p  memory port data_i
mem_w_mask_o  out  width_p  memory port w_mask_i
mem_data_i  in  width_p  memory port data_o

Behaviour:
- Reset (asynchronous, reset_n_i=0) forces:
  - state=CLEAR if clear_on_reset_p, else RUN
  - clear counter = 0
  - rr pointer = 0, meaning requester 0 has priority
  - pending = 0
- Reset outputs: ready_o=0, v_o=0, clear_done_o=0 (1 if clear_on_reset_p=0), mem_v_o=0.
- State CLEAR:
  - Each cycle: mem_v_o=1, mem_w_o=1, mem_addr_o=counter, mem_data_o=0, mem_w_mask_o=all ones.
  - Counter increments by 1 per cycle. At counter==els_p-1, next state is RUN.
  - ready_o=0 throughout. The sweep takes exactly els_p cycles.
  - clear_done_o=1 from the first RUN cycle until the next reset.
- State RUN:
  - issue_ok = ~pending | (yumi_i[owner]).
  - Arbitration is combinational:
    - only one v_i set: that requester wins
    - both set: the requester selected by the rr pointer wins
  - ready_o[winner] = issue_ok. The loser's ready_o is 0.
  - On accept (v_i&ready_o of the winner):
    - memory is driven from the winner's slices; mem_v_o=1
    - rr pointer moves to the other requester, so the requester that did not just win has priority next
  - A write completes in the issue cycle.
  - A read sets pending=1 with owner=winner.
  - No accept: mem_v_o=0 and mem_w_o=0.
- Read response latency is 1 cycle:
  - v_o[owner]=pending; data_o=mem_data_i passed through, not registered.
  - A pending response holds indefinitely until yumi. The memory latch preserves data because no access is issued while pending & ~yumi.
  - yumi plus a new accept in the same cycle gives back-to-back throughput of 1 read per cycle.
  - yumi with no new read clears pending.
- Boundary conditions:
  - A write accepted on the yumi cycle is legal; pending clears at the next edge.
  - addr_i >= els_p is an error: simulation-only assertion on accept; the hardware behaviour is undefined.
  - yumi_i without v_o: assertion.
  - reset_n_i asserted mid-sweep or with a read pending: all state drops at once, any response is lost, and the clear restarts from address 0.
- Requests in CLEAR are held off, never dropped: the requester keeps v_i high; valid/ready is non-destructive.

Decomposition:
- Package bsg_mem_arb_pkg:
  - state enum {eCLEAR, eRUN}
  - constant for the number of requesters (2)
- Natural sub-module: bsg_round_robin_2, holding the pointer and the grant logic.
- Counter and FSM stay in the top module. The memory is not instantiated inside.

Test Plan:
- els_p=16, clear_on_reset_p=1, release reset -> mem_v_o=mem_w_o=1 for exactly 16 cycles, addresses 0..15, mask all ones, data 0. clear_done_o rises on cycle 17, ready_o low until then.
- Requester 0: write addr 3 with data 0xFFFF and mask 0x00F0, then read addr 3 -> v_o[0]=1 the cycle after the read accept, data_o=0x00F0.
- Both requesters v_i=1 continuously, both reading, yumi every cycle -> grants alternate 0,1,0,1 with one accept per cycle and v_o matching the owner.
- Read pending, yumi_i held 0 for 5 cycles -> ready_o=0 for both and mem_v_o=0; data_o stable. Yumi in cycle 6 -> a new request is accepted in that same cycle.
- reset_n_i pulsed low at clear count 7 -> outputs return to reset values immediately (asynchronous); the sweep restarts at address 0.
- clear_on_reset_p=0 -> ready_o available on the first cycle after reset and clear_done_o=1.

Source files
------------

// File: rtl/bsg_mem_arb_pkg.sv
// Shared types and constants for the two-requester arbitrated front end of a
// bit-masked single-port synchronous memory.
package bsg_mem_arb_pkg;

    localparam int unsigned num_req_lp = 2;

    typedef enum logic {
        eCLEAR,
        eRUN
    } state_e;

    // Address width that never collapses to zero bits, even for a one-entry array.
    function automatic int safe_clog2(input int n);
        int unsigned r;
        if (n <= 1) return 1;
        r = 0;
        while ((64'(1) << r) < 64'(n)) r++;
        return int'(r);
    endfunction

endpackage

// File: rtl/bsg_round_robin_2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the pointer
// decides, and every accepted grant hands priority to the other requester.
module bsg_round_robin_2
    import bsg_mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [num_req_lp-1:0] req,
    input  logic                  advance,
    output logic                  winner
);

    logic ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~winner;
        end
    end

    // With no requester asking, the priority holder is nominated so that
    // ready can be offered ahead of valid.
    always_comb begin
        winner = ptr;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_arb.sv
// Shares one bit-masked 1rw synchronous memory (latch_last_read_p=1, instantiated
// by the parent) between two requesters after an optional post-reset clear sweep.
module bsg_mem_1rw_sync_mask_write_bit_arb
    import bsg_mem_arb_pkg::*;
#(
    parameter  int width_p          = -1,
    parameter  int els_p            = -1,
    parameter  bit clear_on_reset_p = 1'b1,
    localparam int addr_width_lp    = safe_clog2(els_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,

    input  logic [num_req_lp-1:0]             v_i,
    input  logic [num_req_lp-1:0]             w_i,
    input  logic [num_req_lp*addr_width_lp-1:0] addr_i,
    input  logic [num_req_lp*width_p-1:0]     data_i,
    input  logic [num_req_lp*width_p-1:0]     w_mask_i,
    output logic [num_req_lp-1:0]             ready_o,

    output logic [num_req_lp-1:0]             v_o,
    output logic [width_p-1:0]                data_o,
    input  logic [num_req_lp-1:0]             yumi_i,

    output logic                              clear_done_o,

    output logic                              mem_v_o,
    output logic                              mem_w_o,
    output logic [addr_width_lp-1:0]          mem_addr_o,
    output logic [width_p-1:0]                mem_data_o,
    output logic [width_p-1:0]                mem_w_mask_o,
    input  logic [width_p-1:0]                mem_data_i
);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                   state, state_n;
    logic [addr_width_lp-1:0] count, count_n;
    logic                     pending, pending_n;
    logic                     owner, owner_n;

    logic                     winner;
    logic                     issue_ok;
    logic                     accept;
    logic                     running;
    logic [addr_width_lp-1:0] win_addr;
    logic [width_p-1:0]       win_data;
    logic [width_p-1:0]       win_mask;

    bsg_round_robin_2 rr (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .req     (v_i),
        .advance (accept),
        .winner  (winner)
    );

    always_comb begin
        if (winner) begin
            win_addr = addr_i[2*addr_width_lp-1:addr_width_lp];
            win_data = data_i[2*width_p-1:width_p];
            win_mask = w_mask_i[2*width_p-1:width_p];
        end else begin
            win_addr = addr_i[addr_width_lp-1:0];
            win_data = data_i[width_p-1:0];
            win_mask = w_mask_i[width_p-1:0];
        end
    end

    // Outputs are gated by the raw reset so they drop the instant reset asserts,
    // including the RUN-state ready when no clear sweep is configured.
    assign running  = reset_n_i && (state == eRUN);
    assign issue_ok = ~pending | yumi_i[owner];
    assign accept   = running & v_i[winner] & issue_ok;

    always_comb begin
        state_n      = state;
        count_n      = count;
        pending_n    = pending;
        owner_n      = owner;
        ready_o      = '0;
        mem_v_o      = 1'b0;
        mem_w_o      = 1'b0;
        mem_addr_o   = win_addr;
        mem_data_o   = win_data;
        mem_w_mask_o = win_mask;

        if (state == eCLEAR) begin
            mem_v_o      = reset_n_i;
            mem_w_o      = reset_n_i;
            mem_addr_o   = count;
            mem_data_o   = '0;
            mem_w_mask_o = '1;
            count_n      = count + addr_width_lp'(1);
            if (count == last_addr_lp) begin
                state_n = eRUN;
            end
        end else begin
            ready_o[winner] = issue_ok & reset_n_i;
            mem_v_o         = accept;
            mem_w_o         = accept & w_i[winner];
            // A consumed response frees the slot; a read accepted in the same
            // cycle immediately re-arms it for the new owner.
            if (accept) begin
                pending_n = ~w_i[winner];
                if (~w_i[winner]) begin
                    owner_n = winner;
                end
            end else if (yumi_i[owner]) begin
                pending_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= clear_on_reset_p ? eCLEAR : eRUN;
            count   <= '0;
            pending <= 1'b0;
            owner   <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            pending <= pending_n;
            owner   <= owner_n;
        end
    end

    always_comb begin
        v_o        = '0;
        v_o[owner] = pending;
    end

    assign data_o       = mem_data_i;
    assign clear_done_o = (state == eRUN);

    addr_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        accept |-> (int'(win_addr) < els_p))
        else $error("accepted request address out of range");

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ((yumi_i & ~v_o) == '0))
        else $error("yumi_i asserted without a valid response");

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_arb.sv
// Randomized bench for the arbitrated memory front end, checked every cycle
// against a transaction-level model of the clear sweep, arbitration and storage.
module tb_bsg_mem_1rw_sync_mask_write_bit_arb;

    localparam int W   = 16;
    localparam int ELS = 16;
    localparam int AW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      v_r, w_r, yumi_r;
    logic [AW-1:0]   addr_r [2];
    logic [W-1:0]    data_r [2];
    logic [W-1:0]    mask_r [2];
    logic [2*AW-1:0] addr_i;
    logic [2*W-1:0]  data_i, mask_i;

    assign addr_i = {addr_r[1], addr_r[0]};
    assign data_i = {data_r[1], data_r[0]};
    assign mask_i = {mask_r[1], mask_r[0]};

    logic [1:0]    ready_o, v_o;
    logic [W-1:0]  data_o;
    logic          clear_done_o;
    logic          mem_v_o, mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_data_o, mem_w_mask_o, mem_data_i;

    bsg_mem_1rw_sync_mask_write_bit_arb #(
        .width_p(W), .els_p(ELS), .clear_on_reset_p(1'b1)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .v_i(v_r), .w_i(w_r), .addr_i(addr_i), .data_i(data_i), .w_mask_i(mask_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_r),
        .clear_done_o(clear_done_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
    );

    // Second instance without the clear sweep; inputs held idle.
    logic [1:0] nc_ready, nc_v_o;
    logic [7:0] nc_data_o, nc_mem_data_o, nc_mem_w_mask_o;
    logic       nc_clear_done, nc_mem_v, nc_mem_w;
    logic [2:0] nc_mem_addr;

    bsg_mem_1rw_sync_mask_write_bit_arb #(
        .width_p(8), .els_p(8), .clear_on_reset_p(1'b0)
    ) dut_nc (
        .clk_i(clk), .reset_n_i(rst_n),
        .v_i(2'b00), .w_i(2'b00), .addr_i(6'd0), .data_i(16'd0), .w_mask_i(16'd0),
        .ready_o(nc_ready), .v_o(nc_v_o), .data_o(nc_data_o), .yumi_i(2'b00),
        .clear_done_o(nc_clear_done),
        .mem_v_o(nc_mem_v), .mem_w_o(nc_mem_w), .mem_addr_o(nc_mem_addr),
        .mem_data_o(nc_mem_data_o), .mem_w_mask_o(nc_mem_w_mask_o), .mem_data_i(8'd0)
    );

    // Memory environment: 1-cycle synchronous read, output latched between reads.
    // Contents are scrambled during reset so only the clear sweep can zero them.
    logic [W-1:0] mem_arr [ELS];
    logic [W-1:0] mem_rd;
    assign mem_data_i = mem_rd;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ELS; i++) mem_arr[i] <= W'($urandom);
        end else if (mem_v_o) begin
            if (mem_w_o)
                mem_arr[mem_addr_o] <= (mem_arr[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
            else
                mem_rd <= mem_arr[mem_addr_o];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: sweep progress, priority holder, outstanding read and the
    // expected array contents.
    bit           m_clearing;
    int           m_idx;
    int           m_prio;
    bit           m_pend;
    int           m_owner;
    logic [W-1:0] m_pend_data;
    logic [W-1:0] ref_mem [ELS];
    bit           m_acc;
    int           m_win;

    always @(negedge clk) begin : compare
        bit         can;
        int         win;
        logic [1:0] exp_ready, exp_vo;
        m_acc = 1'b0;
        if (!rst_n) begin
            check("reset ready_o", ready_o, 0);
            check("reset v_o", v_o, 0);
            check("reset mem_v_o", mem_v_o, 0);
            check("reset clear_done_o", clear_done_o, 0);
        end else if (m_clearing) begin
            check("clear mem_v_o", mem_v_o, 1);
            check("clear mem_w_o", mem_w_o, 1);
            check("clear mem_addr_o", mem_addr_o, m_idx);
            check("clear mem_data_o", mem_data_o, 0);
            check("clear mem_w_mask_o", mem_w_mask_o, 16'hFFFF);
            check("clear ready_o", ready_o, 0);
            check("clear v_o", v_o, 0);
            check("clear clear_done_o", clear_done_o, 0);
        end else begin
            can = !m_pend || yumi_r[m_owner];
            if (v_r == 2'b01)      win = 0;
            else if (v_r == 2'b10) win = 1;
            else                   win = m_prio;
            exp_ready = '0;
            if (can) exp_ready[win] = 1'b1;
            m_acc = v_r[win] && can;
            m_win = win;
            check("run ready_o", ready_o, exp_ready);
            check("run mem_v_o", mem_v_o, m_acc);
            if (m_acc) begin
                check("run mem_w_o", mem_w_o, w_r[win]);
                check("run mem_addr_o", mem_addr_o, addr_r[win]);
                if (w_r[win]) begin
                    check("run mem_data_o", mem_data_o, data_r[win]);
                    check("run mem_w_mask_o", mem_w_mask_o, mask_r[win]);
                end
            end else begin
                check("run idle mem_w_o", mem_w_o, 0);
            end
            exp_vo = '0;
            if (m_pend) exp_vo[m_owner] = 1'b1;
            check("run v_o", v_o, exp_vo);
            if (m_pend) check("run data_o", data_o, m_pend_data);
            check("run clear_done_o", clear_done_o, 1);
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_clearing = 1'b1;
            m_idx      = 0;
            m_prio     = 0;
            m_pend     = 1'b0;
            m_owner    = 0;
        end else if (m_clearing) begin
            ref_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == ELS) m_clearing = 1'b0;
        end else begin
            if (m_pend && yumi_r[m_owner]) m_pend = 1'b0;
            if (m_acc) begin
                m_prio = 1 - m_win;
                if (w_r[m_win]) begin
                    ref_mem[addr_r[m_win]] = (ref_mem[addr_r[m_win]] & ~mask_r[m_win])
                                           | (data_r[m_win] & mask_r[m_win]);
                end else begin
                    m_pend      = 1'b1;
                    m_owner     = m_win;
                    m_pend_data = ref_mem[addr_r[m_win]];
                end
            end
        end
    end

    task automatic idle();
        v_r = '0; w_r = '0; yumi_r = '0;
        for (int r = 0; r < 2; r++) begin
            addr_r[r] = '0; data_r[r] = '0; mask_r[r] = '0;
        end
    endtask

    task automatic yumi_if_pending();
        yumi_r = '0;
        if (m_pend) yumi_r[m_owner] = 1'b1;
    endtask

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                v_r[r]    = ($urandom % 3) != 0;
                w_r[r]    = $urandom % 2;
                addr_r[r] = AW'($urandom_range(0, ELS - 1));
                data_r[r] = W'($urandom);
                mask_r[r] = W'($urandom);
            end
            yumi_r = '0;
            if (m_pend && ($urandom % 4) != 0) yumi_r[m_owner] = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            idle();
            yumi_if_pending();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        logic [1:0] last_ready;
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("nc reset ready_o", nc_ready, 0);
        check("nc reset clear_done_o", nc_clear_done, 1);
        #2 rst_n = 1'b1;

        // Clear sweep: 16 write cycles over addresses 0..15.
        for (int k = 0; k < ELS; k++) begin
            @(negedge clk);
            check("sweep mem_v_o", mem_v_o, 1);
            check("sweep mem_addr_o", mem_addr_o, k);
            check("sweep ready_o", ready_o, 0);
            if (k == 0) begin
                check("nc first ready_o", nc_ready, 2'b01);
                check("nc first clear_done_o", nc_clear_done, 1);
                check("nc first mem_v_o", nc_mem_v, 0);
                check("nc first v_o", nc_v_o, 0);
            end
        end
        @(negedge clk);
        check("clear_done after sweep", clear_done_o, 1);
        check("ready after sweep", ready_o, 2'b01);

        // Masked write then read back through requester 0.
        @(posedge clk); #1;
        v_r = 2'b01; w_r = 2'b01; addr_r[0] = 4'd3; data_r[0] = 16'hFFFF; mask_r[0] = 16'h00F0;
        @(negedge clk);
        check("wr accept mem_w_o", mem_w_o, 1);
        @(posedge clk); #1;
        w_r = 2'b00;
        @(negedge clk);
        check("rd accept mem_v_o", mem_v_o, 1);
        @(posedge clk); #1;
        v_r = 2'b00; yumi_r = 2'b01;
        @(negedge clk);
        check("rd response v_o", v_o, 2'b01);
        check("rd response data_o", data_o, 16'h00F0);

        // Both read every cycle with immediate yumi: grants alternate, starting with 1.
        last_ready = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            v_r = 2'b11; w_r = 2'b00; addr_r[0] = 4'd3; addr_r[1] = 4'd5;
            yumi_if_pending();
            @(negedge clk);
            check("alternate ready_o", ready_o, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("alternate mem_v_o", mem_v_o, 1);
            if (i > 0) check("alternate v_o owner", v_o, last_ready);
            last_ready = ready_o;
        end

        // Response held without yumi for 5 cycles, then released.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            v_r = 2'b11; yumi_r = 2'b00;
            @(negedge clk);
            check("hold ready_o", ready_o, 0);
            check("hold mem_v_o", mem_v_o, 0);
            check("hold v_o", v_o, 2'b01);
            check("hold data_o", data_o, 16'h00F0);
        end
        @(posedge clk); #1;
        yumi_r = 2'b01;
        @(negedge clk);
        check("release ready_o", ready_o, 2'b10);
        check("release mem_v_o", mem_v_o, 1);
        @(posedge clk); #1;
        idle();
        yumi_if_pending();

        random_cycles(400);

        // Reset pulsed at clear count 7.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (m_clearing && m_idx == 7) found = 1'b1;
        end
        check("reach clear count 7", found, 1);
        check("count 7 mem_addr_o", mem_addr_o, 7);
        #1 rst_n = 1'b0;
        #1;
        check("async reset mem_v_o", mem_v_o, 0);
        check("async reset ready_o", ready_o, 0);
        check("async reset clear_done_o", clear_done_o, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("sweep restart mem_addr_o", mem_addr_o, 0);
        check("sweep restart mem_v_o", mem_v_o, 1);
        repeat (20) @(posedge clk);

        // Reset with a read response outstanding drops it at once.
        #1;
        v_r = 2'b01; w_r = 2'b00; addr_r[0] = 4'd3;
        @(posedge clk); #1;
        idle();
        check("pending before reset v_o", v_o, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        check("pending dropped v_o", v_o, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        random_cycles(150);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
